// File: rtl/memcmd_pkg.sv
// ============================================================================
// Module   : memcmd_pkg
// Purpose  : Shared constants, state encoding and command-frame builder for
//            the memory-command protocol initiator.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package memcmd_pkg;

  localparam int ADDR_W  = 19;
  localparam int HDR_LEN = 5;

  localparam logic [1:0] OP_RD   = 2'd0;
  localparam logic [1:0] OP_WR   = 2'd1;
  localparam logic [1:0] OP_REG  = 2'd2;
  localparam logic [1:0] OP_CEDE = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_RREG  = 3'd4,
    ST_FIN   = 3'd5
  } state_e;

  // Command frame, byte 0 in bits [7:0]; one-byte ops only use byte 0.
  function automatic logic [8*HDR_LEN-1:0] build_cmd(
    input logic [1:0]        op,
    input logic [ADDR_W-1:0] base,
    input logic [ADDR_W-1:0] size,
    input logic [4:0]        reg_idx
  );
    logic [8*HDR_LEN-1:0] c;
    c = '0;
    case (op)
      OP_RD, OP_WR: c = {size, base, 1'b0, op[0]};
      OP_REG:       c[7:0] = {reg_idx[3:0], reg_idx[4], 1'b0, 2'b10};
      default:      c[7:0] = 8'h03;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/memcmd_wdog.sv
// ============================================================================
// Module   : memcmd_wdog
// Purpose  : Response watchdog; saturating idle counter with synchronous
//            clear, flags expiry when the count reaches all ones.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module memcmd_wdog #(
  parameter int TO_W = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  assign expired = &cnt_q;

  // Next count: clear wins, then count up while enabled, holding at all ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expired) begin
      cnt_d = cnt_q + TO_W'(1);
    end
  end

  // Counter register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/memcmd_host.sv
// ============================================================================
// Module   : memcmd_host
// Purpose  : Byte-stream initiator: sends read/write/register/cede command
//            frames, streams write payload, collects read data or a 32-bit
//            register word, and reports completion with a watchdog error.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module memcmd_host
  import memcmd_pkg::*;
#(
  parameter int TO_W = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_size,
  input  logic [4:0]        req_reg,
  input  logic [7:0]        wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic [31:0]       reg_word,
  output logic              reg_valid,
  output logic              done,
  output logic              err,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_ready
);

  state_e                 state_q, state_d;
  logic [1:0]             op_q, op_d;
  logic [8*HDR_LEN-1:0]   cmd_q, cmd_d;
  logic [2:0]             hdr_idx_q, hdr_idx_d;
  logic [ADDR_W-1:0]      rem_q, rem_d;
  logic [23:0]            shift_q, shift_d;
  logic [1:0]             byte_cnt_q, byte_cnt_d;
  logic                   to_flag_q, to_flag_d;
  logic                   req_ready_q, req_ready_d;
  logic [7:0]             rd_data_q, rd_data_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [31:0]            reg_word_q, reg_word_d;
  logic                   reg_valid_q, reg_valid_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   wd_clear, wd_enable, wd_expired;
  logic [2:0]             hdr_last;
  logic [7:0]             hdr_byte;

  assign hdr_last  = (op_q == OP_RD || op_q == OP_WR) ? 3'(HDR_LEN - 1) : 3'd0;
  assign hdr_byte  = cmd_q[{hdr_idx_q, 3'b000} +: 8];

  assign req_ready = req_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign reg_word  = reg_word_q;
  assign reg_valid = reg_valid_q;
  assign done      = done_q;
  assign err       = err_q;

  memcmd_wdog #(.TO_W(TO_W)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .expired (wd_expired)
  );

  // Next-state, datapath updates and combinational TX/write handshake.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cmd_d       = cmd_q;
    hdr_idx_d   = hdr_idx_q;
    rem_d       = rem_q;
    shift_d     = shift_q;
    byte_cnt_d  = byte_cnt_q;
    to_flag_d   = to_flag_q;
    rd_data_d   = rd_data_q;
    reg_word_d  = reg_word_q;
    rd_valid_d  = 1'b0;
    reg_valid_d = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    tx_valid    = 1'b0;
    tx_data     = 8'h00;
    wr_ready    = 1'b0;
    wd_clear    = 1'b0;
    wd_enable   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          op_d       = req_op;
          cmd_d      = build_cmd(req_op, req_base, req_size, req_reg);
          rem_d      = req_size;
          hdr_idx_d  = 3'd0;
          byte_cnt_d = 2'd0;
          to_flag_d  = 1'b0;
          state_d    = ST_HDR;
        end
      end

      ST_HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte;
        if (tx_ready) begin
          if (hdr_idx_q == hdr_last) begin
            // Watchdog starts fresh as the response phase begins.
            wd_clear = 1'b1;
            case (op_q)
              OP_RD:   state_d = (rem_q == '0) ? ST_FIN : ST_RDATA;
              OP_WR:   state_d = (rem_q == '0) ? ST_FIN : ST_WDATA;
              OP_REG:  state_d = ST_RREG;
              default: state_d = ST_FIN;
            endcase
          end else begin
            hdr_idx_d = hdr_idx_q + 3'd1;
          end
        end
      end

      ST_WDATA: begin
        tx_valid = wr_valid;
        tx_data  = wr_data;
        wr_ready = tx_ready && wr_valid;
        if (tx_ready && wr_valid) begin
          rem_d = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) begin
            state_d = ST_FIN;
          end
        end
      end

      ST_RDATA: begin
        wd_enable = 1'b1;
        if (rx_ready) begin
          wd_clear   = 1'b1;
          rd_data_d  = rx_data;
          rd_valid_d = 1'b1;
          rem_d      = rem_q - ADDR_W'(1);
          if (rem_q == ADDR_W'(1)) begin
            state_d = ST_FIN;
          end
        end else if (wd_expired) begin
          to_flag_d = 1'b1;
          state_d   = ST_FIN;
        end
      end

      ST_RREG: begin
        wd_enable = 1'b1;
        if (rx_ready) begin
          wd_clear   = 1'b1;
          shift_d    = {rx_data, shift_q[23:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            reg_word_d  = {rx_data, shift_q};
            reg_valid_d = 1'b1;
            state_d     = ST_FIN;
          end
        end else if (wd_expired) begin
          to_flag_d = 1'b1;
          state_d   = ST_FIN;
        end
      end

      ST_FIN: begin
        done_d  = 1'b1;
        err_d   = to_flag_q;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Ready is registered so it stays low through reset and in the done cycle.
  always_comb begin
    req_ready_d = (state_d == ST_IDLE) && (state_q != ST_FIN);
  end

  // State and output registers, asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      op_q        <= 2'd0;
      cmd_q       <= '0;
      hdr_idx_q   <= 3'd0;
      rem_q       <= '0;
      shift_q     <= '0;
      byte_cnt_q  <= 2'd0;
      to_flag_q   <= 1'b0;
      req_ready_q <= 1'b0;
      rd_data_q   <= 8'h00;
      rd_valid_q  <= 1'b0;
      reg_word_q  <= '0;
      reg_valid_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cmd_q       <= cmd_d;
      hdr_idx_q   <= hdr_idx_d;
      rem_q       <= rem_d;
      shift_q     <= shift_d;
      byte_cnt_q  <= byte_cnt_d;
      to_flag_q   <= to_flag_d;
      req_ready_q <= req_ready_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      reg_word_q  <= reg_word_d;
      reg_valid_q <= reg_valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

`default_nettype wire
